// File: rtl/t5_pkg.sv
// Shared definitions for the t5 data-bus controller: FSM encoding,
// access size codes and the default bus timeout.
package t5_pkg;

  // Controller states: IDLE accepts a request, BUSY waits for the bus.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  // funct3[13:12] access size codes; 2'b11 is an illegal size.
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  // Default bus timeout in cycles (only used when the timeout is built in).
  localparam int T5_TMO_DEF = 255;

endpackage

// File: rtl/t5_lanes.sv
// Byte-lane and misalignment decode for one load/store access.
// Purely combinational: size code plus the low address bits in,
// Wishbone byte select and a misaligned/illegal flag out.
module t5_lanes
  import t5_pkg::*;
(
  input  logic [1:0] size,
  input  logic [1:0] adr,
  output logic [3:0] sel,
  output logic       mis
);

  // Decode lanes per size; the illegal size reports as misaligned.
  always_comb begin
    sel = 4'h0;
    mis = 1'b0;
    case (size)
      SZ_B: sel = 4'h1 << adr;
      SZ_H: begin
        sel = adr[1] ? 4'hC : 4'h3;
        mis = adr[0];
      end
      SZ_W: begin
        sel = 4'hF;
        mis = |adr;
      end
      default: begin
        sel = 4'h0;
        mis = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/t5_dwbctl.sv
// t5 data Wishbone controller: turns execute-stage load/store requests
// into single registered Wishbone classic cycles, stalling the pipeline
// while the bus is busy.
// Optional feature macro: T5_DWB_TIMEOUT_EN adds a bus timeout counter
// (limit TMO cycles) that aborts a hung access and pulses derr.
//
// Handshake: the execute stage offers a request with xstb; the request is
// consumed on a rising edge where sena=1. sena=0 holds the pipeline. On the
// bus side cyc/stb stay asserted from BUSY entry until the edge following
// dwb_ack=1 (or the timeout terminal cycle); dwb_ack outside BUSY is ignored.
module t5_dwbctl
  import t5_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int TMO  = T5_TMO_DEF
) (
  input  logic            sclk,
  input  logic            srst,
  input  logic            xstb,
  input  logic            xwre,
  input  logic [2:0]      xfn3,
  input  logic [XLEN-1:0] xadr,
  input  logic [XLEN-1:0] xdat,
  input  logic [1:0]      xhart,
  input  logic            dwb_ack,
  output logic            dwb_cyc,
  output logic            dwb_stb,
  output logic            dwb_we,
  output logic [XLEN-1:0] dwb_adr,
  output logic [3:0]      dwb_sel,
  output logic [XLEN-1:0] dwb_dto,
  output logic [3:0]      xsel,
  output logic            sena,
  output logic            dmis,
  output logic            derr,
  output logic [1:0]      dhart,
  output state_e          dbg_state
);

  state_e          state, state_nxt;
  logic [3:0]      lsel;
  logic            lmis;
  logic            start;
  logic            tmo_hit;
  logic [XLEN-1:0] rep_dat;

  // The unsigned flag is consumed by the writeback extender, not here.
  logic unused_fn3;
  assign unused_fn3 = xfn3[2];

  t5_lanes u_lanes (
    .size (xfn3[1:0]),
    .adr  (xadr[1:0]),
    .sel  (lsel),
    .mis  (lmis)
  );

  assign xsel      = dwb_sel;
  assign dbg_state = state;

  // Replicate store data across every lane the access could select.
  always_comb begin
    case (xfn3[1:0])
      SZ_B:    rep_dat = {(XLEN/8){xdat[7:0]}};
      SZ_H:    rep_dat = {(XLEN/16){xdat[15:0]}};
      default: rep_dat = xdat;
    endcase
  end

`ifdef T5_DWB_TIMEOUT_EN
  localparam int CW = (TMO < 2) ? 1 : $clog2(TMO + 1);
  logic [CW-1:0] tmo_cnt;
  logic          derr_q;

  assign tmo_hit = (tmo_cnt == CW'(TMO));
  assign derr    = derr_q;

  // Count unacknowledged BUSY cycles; restart on every new access.
  always_ff @(posedge sclk) begin
    if (srst) begin
      tmo_cnt <= '0;
      derr_q  <= 1'b0;
    end else begin
      derr_q <= (state == ST_BUSY) && !dwb_ack && tmo_hit;
      if (start)
        tmo_cnt <= '0;
      else if ((state == ST_BUSY) && !dwb_ack && !tmo_hit)
        tmo_cnt <= tmo_cnt + 1'b1;
    end
  end
`else
  assign tmo_hit = 1'b0;
  assign derr    = 1'b0;
`endif

  // Next state and pipeline enable; sena defaults high everywhere else.
  always_comb begin
    state_nxt = state;
    sena      = 1'b1;
    start     = 1'b0;
    if (!srst) begin
      case (state)
        ST_IDLE: begin
          if (xstb && !lmis) begin
            sena      = 1'b0;
            start     = 1'b1;
            state_nxt = ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (dwb_ack || tmo_hit) begin
            sena      = 1'b1;
            state_nxt = ST_IDLE;
          end else begin
            sena = 1'b0;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge sclk) begin
    if (srst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  // Registered bus controls, data, hart tag and the misalign pulse.
  always_ff @(posedge sclk) begin
    if (srst) begin
      dwb_cyc <= 1'b0;
      dwb_stb <= 1'b0;
      dwb_we  <= 1'b0;
      dwb_adr <= '0;
      dwb_sel <= 4'h0;
      dwb_dto <= '0;
      dmis    <= 1'b0;
      dhart   <= 2'd0;
    end else begin
      dmis <= 1'b0;
      if (start) begin
        dwb_cyc <= 1'b1;
        dwb_stb <= 1'b1;
        dwb_we  <= xwre;
        dwb_adr <= {xadr[XLEN-1:2], 2'b00};
        dwb_sel <= lsel;
        dwb_dto <= rep_dat;
        dhart   <= xhart;
      end else if ((state == ST_IDLE) && xstb && lmis) begin
        dmis  <= 1'b1;
        dhart <= xhart;
      end else if ((state == ST_BUSY) && (state_nxt == ST_IDLE)) begin
        dwb_cyc <= 1'b0;
        dwb_stb <= 1'b0;
        dwb_we  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_t5_dwbctl.sv
// Directed testbench for t5_dwbctl: reset, stores/loads, misalignment,
// reset during BUSY, back-to-back hart sequencing and (when built with
// T5_DWB_TIMEOUT_EN) the bus timeout.
module tb_t5_dwbctl;
  import t5_pkg::*;

  logic        sclk;
  logic        srst;
  logic        xstb;
  logic        xwre;
  logic [2:0]  xfn3;
  logic [31:0] xadr;
  logic [31:0] xdat;
  logic [1:0]  xhart;
  logic        dwb_ack;
  logic        dwb_cyc, dwb_stb, dwb_we;
  logic [31:0] dwb_adr;
  logic [3:0]  dwb_sel;
  logic [31:0] dwb_dto;
  logic [3:0]  xsel;
  logic        sena, dmis, derr;
  logic [1:0]  dhart;
  state_e      dbg_state;

  int n_vec = 0;
  int n_err = 0;
  logic [1:0] exp_q[$];

`ifdef T5_DWB_TIMEOUT_EN
  t5_dwbctl #(.XLEN(32), .TMO(4)) dut (
`else
  t5_dwbctl #(.XLEN(32)) dut (
`endif
    .sclk(sclk), .srst(srst), .xstb(xstb), .xwre(xwre), .xfn3(xfn3),
    .xadr(xadr), .xdat(xdat), .xhart(xhart), .dwb_ack(dwb_ack),
    .dwb_cyc(dwb_cyc), .dwb_stb(dwb_stb), .dwb_we(dwb_we),
    .dwb_adr(dwb_adr), .dwb_sel(dwb_sel), .dwb_dto(dwb_dto),
    .xsel(xsel), .sena(sena), .dmis(dmis), .derr(derr),
    .dhart(dhart), .dbg_state(dbg_state)
  );

  // Clock and watchdog.
  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge sclk);
    #1;
  endtask

  task automatic test_reset();
    srst = 1'b1; xstb = 1'b1; xwre = 1'b1; xfn3 = 3'b010; xadr = 32'h0; xdat = 32'h0;
    xhart = 2'd3; dwb_ack = 1'b0;
    step(); step();
    #1;
    n_vec++; if (sena !== 1'b1) begin n_err++; $display("FAIL rst_sena: got %b want 1", sena); end
    n_vec++; if ({dwb_cyc, dwb_stb, dwb_we} !== 3'b000) begin n_err++; $display("FAIL rst_ctl: got %b want 000", {dwb_cyc, dwb_stb, dwb_we}); end
    n_vec++; if (dwb_adr !== 32'h0) begin n_err++; $display("FAIL rst_adr: got %h want 0", dwb_adr); end
    n_vec++; if (dwb_sel !== 4'h0) begin n_err++; $display("FAIL rst_sel: got %h want 0", dwb_sel); end
    n_vec++; if (dwb_dto !== 32'h0) begin n_err++; $display("FAIL rst_dto: got %h want 0", dwb_dto); end
    n_vec++; if ({dmis, derr, dhart} !== 4'b0000) begin n_err++; $display("FAIL rst_flags: got %b want 0000", {dmis, derr, dhart}); end
    n_vec++; if (dbg_state !== ST_IDLE) begin n_err++; $display("FAIL rst_state: got %0d want IDLE", dbg_state); end
    srst = 1'b0; xstb = 1'b0; xhart = 2'd0;
  endtask

  task automatic test_ack_idle();
    step(); dwb_ack = 1'b1; #1;
    n_vec++; if (sena !== 1'b1) begin n_err++; $display("FAIL ackidle_sena: got %b want 1", sena); end
    step(); dwb_ack = 1'b0; #1;
    n_vec++; if (dwb_cyc !== 1'b0 || dbg_state !== ST_IDLE) begin n_err++; $display("FAIL ackidle_state: got cyc=%b st=%0d want cyc=0 IDLE", dwb_cyc, dbg_state); end
  endtask

  task automatic test_byte_store();
    step(); xstb = 1'b1; xwre = 1'b1; xfn3 = 3'b000; xadr = 32'h1003; xdat = 32'h0000_00A5; xhart = 2'd1; #1;
    n_vec++; if (sena !== 1'b0) begin n_err++; $display("FAIL bst_req_sena: got %b want 0", sena); end
    step(); xstb = 1'b0; dwb_ack = 1'b1; #1;
    n_vec++; if ({dwb_cyc, dwb_stb, dwb_we} !== 3'b111) begin n_err++; $display("FAIL bst_ctl: got %b want 111", {dwb_cyc, dwb_stb, dwb_we}); end
    n_vec++; if (dwb_adr !== 32'h1000) begin n_err++; $display("FAIL bst_adr: got %h want 00001000", dwb_adr); end
    n_vec++; if (dwb_sel !== 4'h8 || xsel !== 4'h8) begin n_err++; $display("FAIL bst_sel: got %h/%h want 8/8", dwb_sel, xsel); end
    n_vec++; if (dwb_dto !== 32'hA5A5_A5A5) begin n_err++; $display("FAIL bst_dto: got %h want a5a5a5a5", dwb_dto); end
    n_vec++; if (sena !== 1'b1 || dhart !== 2'd1) begin n_err++; $display("FAIL bst_ack: got sena=%b dhart=%0d want 1/1", sena, dhart); end
    step(); dwb_ack = 1'b0; #1;
    n_vec++; if (dwb_cyc !== 1'b0 || dwb_we !== 1'b0 || dbg_state !== ST_IDLE) begin n_err++; $display("FAIL bst_done: got cyc=%b we=%b st=%0d want 0 0 IDLE", dwb_cyc, dwb_we, dbg_state); end
    n_vec++; if (dwb_sel !== 4'h8) begin n_err++; $display("FAIL bst_selhold: got %h want 8", dwb_sel); end
  endtask

  task automatic test_half_load();
    int cyc_cnt;
    cyc_cnt = 0;
    step(); xstb = 1'b1; xwre = 1'b0; xfn3 = 3'b001; xadr = 32'h2002; xdat = 32'h1234_5678; xhart = 2'd2; #1;
    n_vec++; if (sena !== 1'b0) begin n_err++; $display("FAIL hld_req_sena: got %b want 0", sena); end
    step(); xstb = 1'b0;
    for (int w = 0; w < 3; w++) begin
      #1;
      if (dwb_cyc === 1'b1) cyc_cnt++;
      n_vec++; if (sena !== 1'b0 || derr !== 1'b0) begin n_err++; $display("FAIL hld_wait%0d: got sena=%b derr=%b want 0 0", w, sena, derr); end
      step();
    end
    dwb_ack = 1'b1; #1;
    if (dwb_cyc === 1'b1) cyc_cnt++;
    n_vec++; if (sena !== 1'b1) begin n_err++; $display("FAIL hld_ack_sena: got %b want 1", sena); end
    n_vec++; if (dwb_sel !== 4'hC || dwb_we !== 1'b0 || dwb_adr !== 32'h2000) begin n_err++; $display("FAIL hld_bus: got sel=%h we=%b adr=%h want c 0 00002000", dwb_sel, dwb_we, dwb_adr); end
    n_vec++; if (dwb_dto !== 32'h5678_5678) begin n_err++; $display("FAIL hld_dto: got %h want 56785678", dwb_dto); end
    step(); dwb_ack = 1'b0; #1;
    n_vec++; if (cyc_cnt !== 4) begin n_err++; $display("FAIL hld_cyclen: got %0d want 4", cyc_cnt); end
    n_vec++; if (dwb_cyc !== 1'b0 || xsel !== 4'hC) begin n_err++; $display("FAIL hld_done: got cyc=%b xsel=%h want 0 c", dwb_cyc, xsel); end
  endtask

  task automatic test_misaligned();
    step(); xstb = 1'b1; xwre = 1'b0; xfn3 = 3'b010; xadr = 32'h3001; xhart = 2'd2; #1;
    n_vec++; if (sena !== 1'b1) begin n_err++; $display("FAIL mis_sena: got %b want 1", sena); end
    step(); xstb = 1'b0; #1;
    n_vec++; if (dmis !== 1'b1 || dhart !== 2'd2) begin n_err++; $display("FAIL mis_pulse: got dmis=%b dhart=%0d want 1 2", dmis, dhart); end
    n_vec++; if (dwb_cyc !== 1'b0 || dbg_state !== ST_IDLE) begin n_err++; $display("FAIL mis_nobus: got cyc=%b st=%0d want 0 IDLE", dwb_cyc, dbg_state); end
    step(); #1;
    n_vec++; if (dmis !== 1'b0) begin n_err++; $display("FAIL mis_oneshot: got %b want 0", dmis); end
    // Illegal size code on an aligned address.
    step(); xstb = 1'b1; xfn3 = 3'b011; xadr = 32'h3000; xhart = 2'd3; #1;
    n_vec++; if (sena !== 1'b1) begin n_err++; $display("FAIL ill_sena: got %b want 1", sena); end
    step(); xstb = 1'b0; #1;
    n_vec++; if (dmis !== 1'b1 || dhart !== 2'd3 || dwb_cyc !== 1'b0) begin n_err++; $display("FAIL ill_pulse: got dmis=%b dhart=%0d cyc=%b want 1 3 0", dmis, dhart, dwb_cyc); end
    // Halfword at an odd address.
    step(); xstb = 1'b1; xfn3 = 3'b101; xadr = 32'h3005; xhart = 2'd1; #1;
    step(); xstb = 1'b0; #1;
    n_vec++; if (dmis !== 1'b1 || dhart !== 2'd1 || dwb_cyc !== 1'b0) begin n_err++; $display("FAIL hmis_pulse: got dmis=%b dhart=%0d cyc=%b want 1 1 0", dmis, dhart, dwb_cyc); end
  endtask

  task automatic test_reset_busy();
    step(); xstb = 1'b1; xwre = 1'b1; xfn3 = 3'b010; xadr = 32'h4000; xdat = 32'hDEAD_BEEF; xhart = 2'd3; #1;
    step(); xstb = 1'b0; #1;
    n_vec++; if (dwb_cyc !== 1'b1 || dwb_dto !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL rb_busy: got cyc=%b dto=%h want 1 deadbeef", dwb_cyc, dwb_dto); end
    step(); srst = 1'b1; dwb_ack = 1'b1; #1;
    n_vec++; if (sena !== 1'b1) begin n_err++; $display("FAIL rb_sena: got %b want 1", sena); end
    step(); srst = 1'b0; dwb_ack = 1'b0; #1;
    n_vec++; if ({dwb_cyc, dwb_stb} !== 2'b00 || dbg_state !== ST_IDLE) begin n_err++; $display("FAIL rb_drop: got cyc/stb=%b st=%0d want 00 IDLE", {dwb_cyc, dwb_stb}, dbg_state); end
    n_vec++; if (dhart !== 2'd0 || dwb_sel !== 4'h0) begin n_err++; $display("FAIL rb_clear: got dhart=%0d sel=%h want 0 0", dhart, dwb_sel); end
    step(); #1;
    n_vec++; if (dwb_cyc !== 1'b0) begin n_err++; $display("FAIL rb_idle: got cyc=%b want 0", dwb_cyc); end
  endtask

  task automatic test_back_to_back();
    for (int h = 0; h < 4; h++) exp_q.push_back(2'(h));
    step(); xstb = 1'b1; xwre = 1'b0; xfn3 = 3'b010; xadr = 32'h5000; xhart = 2'd0;
    for (int h = 0; h < 4; h++) begin
      #1;
      n_vec++; if (sena !== 1'b0 || dbg_state !== ST_IDLE) begin n_err++; $display("FAIL b2b_req%0d: got sena=%b st=%0d want 0 IDLE", h, sena, dbg_state); end
      step();
      dwb_ack = 1'b1;
      if (h < 3) begin
        xhart = 2'(h + 1);
        xadr  = 32'h5000 + 32'(4 * (h + 1));
      end else begin
        xstb = 1'b0;
      end
      #1;
      n_vec++; if (dwb_cyc !== 1'b1 || dhart !== exp_q.pop_front() || sena !== 1'b1) begin n_err++; $display("FAIL b2b_bus%0d: got cyc=%b dhart=%0d sena=%b want 1 %0d 1", h, dwb_cyc, dhart, sena, h); end
      step(); dwb_ack = 1'b0; #1;
      n_vec++; if (dwb_cyc !== 1'b0) begin n_err++; $display("FAIL b2b_gap%0d: got cyc=%b want 0", h, dwb_cyc); end
    end
    step(); #1;
    n_vec++; if (dwb_cyc !== 1'b0 || exp_q.size() != 0) begin n_err++; $display("FAIL b2b_end: got cyc=%b left=%0d want 0 0", dwb_cyc, exp_q.size()); end
  endtask

`ifdef T5_DWB_TIMEOUT_EN
  task automatic test_timeout();
    step(); xstb = 1'b1; xwre = 1'b0; xfn3 = 3'b010; xadr = 32'h6000; xhart = 2'd1; #1;
    step(); xstb = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_vec++; if (dwb_cyc !== 1'b1 || sena !== 1'b0) begin n_err++; $display("FAIL tmo_wait%0d: got cyc=%b sena=%b want 1 0", i, dwb_cyc, sena); end
      step();
    end
    #1;
    n_vec++; if (dwb_cyc !== 1'b1 || sena !== 1'b1 || derr !== 1'b0) begin n_err++; $display("FAIL tmo_term: got cyc=%b sena=%b derr=%b want 1 1 0", dwb_cyc, sena, derr); end
    step(); #1;
    n_vec++; if (dwb_cyc !== 1'b0 || derr !== 1'b1 || dbg_state !== ST_IDLE) begin n_err++; $display("FAIL tmo_err: got cyc=%b derr=%b st=%0d want 0 1 IDLE", dwb_cyc, derr, dbg_state); end
    step(); #1;
    n_vec++; if (derr !== 1'b0) begin n_err++; $display("FAIL tmo_oneshot: got %b want 0", derr); end
  endtask
`endif

  initial begin
    test_reset();
    test_ack_idle();
    test_byte_store();
    test_half_load();
    test_misaligned();
    test_reset_busy();
    test_back_to_back();
`ifdef T5_DWB_TIMEOUT_EN
    test_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
